// File: rtl/mymul_pkg.sv
// mymul_pkg
// Shared definitions for the sequential multiplier slave: register word
// offsets, CTRL/STATUS bit positions and the datapath FSM state encoding.
package mymul_pkg;

  // Register word offsets on the slave port
  localparam int unsigned REG_A         = 0;
  localparam int unsigned REG_B         = 1;
  localparam int unsigned REG_RESULT_LO = 2;
  localparam int unsigned REG_RESULT_HI = 3;
  localparam int unsigned REG_CTRL      = 4;
  localparam int unsigned REG_STATUS    = 5;

  // CTRL register bits
  localparam int CTRL_START  = 0;
  localparam int CTRL_SIGNED = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS register bits
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  // Datapath sequencing
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/mymul_seq_core.sv
// mymul_seq_core
// Iterative shift-add multiplier. On start it captures operand magnitudes
// (two's-complement absolute values in signed mode) and the result sign,
// performs one shift-add step per cycle for DATA_W cycles, then spends one
// cycle in FIN where the signed product is presented.
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset; aborts any running operation
//   start     begin a multiplication (ignored unless idle)
//   is_signed treat a/b as two's-complement for this operation
//   a, b      DATA_W-bit operands, sampled on start
//   busy      high from the start edge until the FIN edge
//   valid     high for the single FIN cycle; product is valid while high
//   product   2*DATA_W-bit result (sign-corrected accumulator)
module mymul_seq_core
  import mymul_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  valid,
  output logic [2*DATA_W-1:0]   product
);

  localparam int PW    = 2 * DATA_W;
  localparam int CNT_W = $clog2(DATA_W);

  state_t             state;
  logic [PW-1:0]      mcand;
  logic [PW-1:0]      acc;
  logic [DATA_W-1:0]  mplier;
  logic [CNT_W-1:0]   cnt;
  logic               negate;

  logic               a_neg;
  logic               b_neg;
  logic [DATA_W-1:0]  a_mag;
  logic [DATA_W-1:0]  b_mag;

  // Operand magnitudes. The most-negative value negates to itself, which
  // read as unsigned is exactly its magnitude, so no special case is needed.
  always_comb begin
    a_neg = is_signed & a[DATA_W-1];
    b_neg = is_signed & b[DATA_W-1];
    a_mag = a_neg ? (~a + DATA_W'(1)) : a;
    b_mag = b_neg ? (~b + DATA_W'(1)) : b;
  end

  // Sequencer and datapath: multiplicand shifts left, multiplier shifts
  // right, and the accumulator adds the multiplicand when the multiplier
  // LSB is set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      negate <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{DATA_W{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            cnt    <= '0;
            negate <= a_neg ^ b_neg;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            state <= FIN;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // A zero accumulator negates to zero, so a signed 0 x negative still
  // yields a clean zero.
  always_comb begin
    valid   = (state == FIN);
    product = negate ? (~acc + PW'(1)) : acc;
  end

endmodule

// File: rtl/mymul_seq.sv
// mymul_seq
// Avalon-MM multiplier slave. Holds the register file (A, B, RESULT_LO/HI,
// CTRL mode bits, STATUS busy/done), decodes bus accesses, drives the
// zero-latency readdata mux and the level interrupt irq = done & irq_en.
// The multiplication itself runs in mymul_seq_core.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    word address
//   read       read strobe; readdata is 0 when low
//   readdata   combinational read data, zero-extended
//   write      write strobe
//   writedata  write data
//   irq        level interrupt
module mymul_seq
  import mymul_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  output logic [31:0]       readdata,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic              irq
);

  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   res_lo_q;
  logic [DATA_W-1:0]   res_hi_q;
  logic                signed_q;
  logic                irq_en_q;
  logic                done_q;

  logic                sel_a;
  logic                sel_b;
  logic                sel_ctrl;
  logic                sel_status;
  logic                start_pulse;
  logic                core_busy;
  logic                core_valid;
  logic [2*DATA_W-1:0] core_product;
  logic                unused_wdata;

  assign sel_a      = (address == ADDR_W'(REG_A));
  assign sel_b      = (address == ADDR_W'(REG_B));
  assign sel_ctrl   = (address == ADDR_W'(REG_CTRL));
  assign sel_status = (address == ADDR_W'(REG_STATUS));

  // Start is honoured only when idle; a start during an operation is dropped.
  assign start_pulse  = write & sel_ctrl & writedata[CTRL_START] & ~core_busy;
  assign unused_wdata = ^writedata;

  // The signed bit is taken straight from the start write so the operation
  // uses the mode written alongside start.
  mymul_seq_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start_pulse),
    .is_signed (writedata[CTRL_SIGNED]),
    .a         (a_q),
    .b         (b_q),
    .busy      (core_busy),
    .valid     (core_valid),
    .product   (core_product)
  );

  // Register file. Operands are frozen while busy; mode bits follow every
  // CTRL write but the core has already latched the mode for the running
  // operation. FIN has priority over a done-clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      signed_q <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (write && sel_a && !core_busy) begin
        a_q <= writedata[DATA_W-1:0];
      end
      if (write && sel_b && !core_busy) begin
        b_q <= writedata[DATA_W-1:0];
      end
      if (write && sel_ctrl) begin
        signed_q <= writedata[CTRL_SIGNED];
        irq_en_q <= writedata[CTRL_IRQ_EN];
      end
      if (core_valid) begin
        res_lo_q <= core_product[DATA_W-1:0];
        res_hi_q <= core_product[2*DATA_W-1:DATA_W];
      end
      if (core_valid) begin
        done_q <= 1'b1;
      end else if (start_pulse) begin
        done_q <= 1'b0;
      end else if (write && sel_status && writedata[STATUS_DONE]) begin
        done_q <= 1'b0;
      end
    end
  end

  // Zero-latency read mux; unused offsets and idle bus read as zero.
  always_comb begin
    readdata = '0;
    if (read) begin
      case (address)
        ADDR_W'(REG_A):         readdata = 32'(a_q);
        ADDR_W'(REG_B):         readdata = 32'(b_q);
        ADDR_W'(REG_RESULT_LO): readdata = 32'(res_lo_q);
        ADDR_W'(REG_RESULT_HI): readdata = 32'(res_hi_q);
        ADDR_W'(REG_CTRL):      readdata = {29'd0, irq_en_q, signed_q, 1'b0};
        ADDR_W'(REG_STATUS):    readdata = {30'd0, done_q, core_busy};
        default:                readdata = '0;
      endcase
    end
  end

  assign irq = done_q & irq_en_q;

endmodule

// File: tb/tb_mymul_seq.sv
// tb_mymul_seq
// Self-checking bench for mymul_seq. Two instances (DATA_W=32 and DATA_W=8)
// share one bus; each scenario task drives the bus, pushes reference products
// into a scoreboard queue at start, and pops/compares when the DUT finishes.
module tb_mymul_seq;
  import mymul_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] rd32;
  logic [31:0] rd8;
  logic        irq32;
  logic        irq8;

  int checks   = 0;
  int failures = 0;
  int irq_rises = 0;
  logic irq32_d = 1'b0;

  logic [63:0] sb32[$];
  logic [15:0] sb8[$];

  // 100 MHz clock
  always #5 clk = ~clk;

  mymul_seq #(.DATA_W(32), .ADDR_W(3)) dut32 (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read),
    .readdata(rd32), .write(write), .writedata(writedata), .irq(irq32)
  );

  mymul_seq #(.DATA_W(8), .ADDR_W(3)) dut8 (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read),
    .readdata(rd8), .write(write), .writedata(writedata), .irq(irq8)
  );

  // Count rising edges of the 32-bit instance interrupt
  always @(posedge clk) begin
    irq32_d <= irq32;
    if (irq32 && !irq32_d) irq_rises <= irq_rises + 1;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference models
  function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (sgn) begin
      sa = 64'($signed(a));
      sb = 64'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input bit sgn);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    if (sgn) begin
      sa = 16'($signed(a));
      sb = 16'($signed(b));
      return 16'(sa * sb);
    end
    return {8'd0, a} * {8'd0, b};
  endfunction

  // Bus helpers
  task automatic bus_write(input int unsigned addr, input logic [31:0] data);
    @(negedge clk);
    address   = 3'(addr);
    writedata = data;
    write     = 1'b1;
    @(negedge clk);
    write     = 1'b0;
    writedata = '0;
  endtask

  task automatic bus_read(input int unsigned addr, output logic [31:0] d32, output logic [31:0] d8);
    @(negedge clk);
    address = 3'(addr);
    read    = 1'b1;
    #1;
    d32  = rd32;
    d8   = rd8;
    read = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ctrl);
    bus_write(REG_A, a);
    bus_write(REG_B, b);
    bus_write(REG_CTRL, ctrl);
  endtask

  // Poll STATUS.busy each cycle until it drops, counting busy cycles
  task automatic wait_idle(input bit use8, output int busy_cycles, output bit timed_out);
    logic [31:0] s;
    busy_cycles = 0;
    timed_out   = 1'b1;
    address     = 3'(REG_STATUS);
    read        = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1;
      s = use8 ? rd8 : rd32;
      if (!s[STATUS_BUSY]) begin
        timed_out = 1'b0;
        break;
      end
      busy_cycles++;
      @(negedge clk);
    end
    read = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d32, d8;
    reset_n = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus_read(a, d32, d8);
      checks++;
      if (d32 !== 32'd0) begin failures++; $display("[TB] FAIL reset_reg32[%0d]: got %h expected 0", a, d32); end
      checks++;
      if (d8 !== 32'd0) begin failures++; $display("[TB] FAIL reset_reg8[%0d]: got %h expected 0", a, d8); end
    end
    checks++;
    if (irq32 !== 1'b0 || irq8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_irq: got %b/%b expected 0/0", irq32, irq8); end
    checks++;
    if (rd32 !== 32'd0) begin failures++; $display("[TB] FAIL idle_readdata: got %h expected 0", rd32); end
  endtask

  task automatic test_unsigned_basic();
    logic [31:0] d32, d8;
    logic [63:0] exp;
    int cyc; bit to;
    applyStimulus(32'd7, 32'd6, 32'h1);
    sb32.push_back(model32(32'd7, 32'd6, 1'b0));
    wait_idle(1'b0, cyc, to);
    checks++;
    if (to || cyc != 33) begin failures++; $display("[TB] FAIL busy_cycles: got %0d timeout=%0b expected 33", cyc, to); end
    bus_read(REG_STATUS, d32, d8);
    checks++;
    if (d32 !== 32'h2) begin failures++; $display("[TB] FAIL status_done: got %h expected 00000002", d32); end
    exp = sb32.pop_front();
    bus_read(REG_RESULT_LO, d32, d8);
    checks++;
    if (d32 !== exp[31:0] || d32 !== 32'd42) begin failures++; $display("[TB] FAIL basic_lo: got %h expected %h", d32, exp[31:0]); end
    bus_read(REG_RESULT_HI, d32, d8);
    checks++;
    if (d32 !== exp[63:32]) begin failures++; $display("[TB] FAIL basic_hi: got %h expected %h", d32, exp[63:32]); end
  endtask

  task automatic test_unsigned_max();
    logic [31:0] d32, d8;
    logic [63:0] exp;
    int cyc; bit to;
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
    sb32.push_back(model32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0));
    wait_idle(1'b0, cyc, to);
    checks++;
    if (to) begin failures++; $display("[TB] FAIL max_timeout: got timeout expected completion"); end
    exp = sb32.pop_front();
    bus_read(REG_RESULT_LO, d32, d8);
    checks++;
    if (d32 !== exp[31:0]) begin failures++; $display("[TB] FAIL max_lo: got %h expected %h", d32, exp[31:0]); end
    bus_read(REG_RESULT_HI, d32, d8);
    checks++;
    if (d32 !== exp[63:32]) begin failures++; $display("[TB] FAIL max_hi: got %h expected %h", d32, exp[63:32]); end
  endtask

  task automatic test_signed_irq();
    logic [31:0] d32, d8;
    logic [63:0] exp;
    int cyc; bit to;
    applyStimulus(32'hFFFF_FFFD, 32'd5, 32'h7);
    sb32.push_back(model32(32'hFFFF_FFFD, 32'd5, 1'b1));
    wait_idle(1'b0, cyc, to);
    checks++;
    if (to || irq32 !== 1'b1) begin failures++; $display("[TB] FAIL signed_irq_set: got %b expected 1", irq32); end
    exp = sb32.pop_front();
    bus_read(REG_RESULT_LO, d32, d8);
    checks++;
    if (d32 !== exp[31:0]) begin failures++; $display("[TB] FAIL signed_lo: got %h expected %h", d32, exp[31:0]); end
    bus_read(REG_RESULT_HI, d32, d8);
    checks++;
    if (d32 !== exp[63:32]) begin failures++; $display("[TB] FAIL signed_hi: got %h expected %h", d32, exp[63:32]); end
    bus_read(REG_CTRL, d32, d8);
    checks++;
    if (d32 !== 32'h6) begin failures++; $display("[TB] FAIL ctrl_readback: got %h expected 00000006", d32); end
    bus_write(REG_STATUS, 32'h2);
    bus_read(REG_STATUS, d32, d8);
    checks++;
    if (d32 !== 32'h0) begin failures++; $display("[TB] FAIL done_clear: got %h expected 00000000", d32); end
    checks++;
    if (irq32 !== 1'b0) begin failures++; $display("[TB] FAIL irq_clear: got %b expected 0", irq32); end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] d32, d8;
    logic [63:0] exp;
    int cyc, base; bit to;
    base = irq_rises;
    applyStimulus(32'd3, 32'd4, 32'h5);
    sb32.push_back(model32(32'd3, 32'd4, 1'b0));
    bus_write(REG_A, 32'd100);
    bus_write(REG_CTRL, 32'h5);
    wait_idle(1'b0, cyc, to);
    checks++;
    if (to) begin failures++; $display("[TB] FAIL busy_ignore_timeout: got timeout expected completion"); end
    repeat (40) @(negedge clk);
    checks++;
    if (irq_rises - base != 1) begin failures++; $display("[TB] FAIL done_rises: got %0d expected 1", irq_rises - base); end
    bus_read(REG_A, d32, d8);
    checks++;
    if (d32 !== 32'd3) begin failures++; $display("[TB] FAIL a_frozen: got %h expected 00000003", d32); end
    exp = sb32.pop_front();
    bus_read(REG_RESULT_LO, d32, d8);
    checks++;
    if (d32 !== exp[31:0] || d32 !== 32'd12) begin failures++; $display("[TB] FAIL busy_lo: got %h expected %h", d32, exp[31:0]); end
  endtask

  task automatic test_width8_signed();
    logic [31:0] d32, d8;
    logic [15:0] exp;
    int cyc; bit to;
    applyStimulus(32'h80, 32'h80, 32'h3);
    sb8.push_back(model8(8'h80, 8'h80, 1'b1));
    wait_idle(1'b1, cyc, to);
    checks++;
    if (to || cyc != 9) begin failures++; $display("[TB] FAIL busy_cycles8: got %0d timeout=%0b expected 9", cyc, to); end
    exp = sb8.pop_front();
    bus_read(REG_RESULT_LO, d32, d8);
    checks++;
    if (d8 !== {24'd0, exp[7:0]}) begin failures++; $display("[TB] FAIL w8_lo: got %h expected %h", d8, exp[7:0]); end
    bus_read(REG_RESULT_HI, d32, d8);
    checks++;
    if (d8 !== {24'd0, exp[15:8]}) begin failures++; $display("[TB] FAIL w8_hi: got %h expected %h", d8, exp[15:8]); end
    for (int a = 6; a < 8; a++) begin
      bus_read(a, d32, d8);
      checks++;
      if (d32 !== 32'd0 || d8 !== 32'd0) begin failures++; $display("[TB] FAIL unmapped[%0d]: got %h/%h expected 0", a, d32, d8); end
    end
    wait_idle(1'b0, cyc, to);
    checks++;
    if (to) begin failures++; $display("[TB] FAIL w8_dut32_timeout: got timeout expected idle"); end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] d32, d8;
    logic [63:0] exp;
    int cyc; bit to;
    int unsigned regs[6] = '{REG_A, REG_B, REG_RESULT_LO, REG_RESULT_HI, REG_CTRL, REG_STATUS};
    applyStimulus(32'd9, 32'd9, 32'h5);
    sb32.push_back(model32(32'd9, 32'd9, 1'b0));
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    sb32.delete();
    #1;
    checks++;
    if (irq32 !== 1'b0) begin failures++; $display("[TB] FAIL midrun_irq: got %b expected 0", irq32); end
    foreach (regs[i]) begin
      bus_read(regs[i], d32, d8);
      checks++;
      if (d32 !== 32'd0) begin failures++; $display("[TB] FAIL midrun_reg[%0d]: got %h expected 0", regs[i], d32); end
    end
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(32'd2, 32'd3, 32'h1);
    sb32.push_back(model32(32'd2, 32'd3, 1'b0));
    wait_idle(1'b0, cyc, to);
    checks++;
    if (to || cyc != 33) begin failures++; $display("[TB] FAIL post_reset_busy: got %0d timeout=%0b expected 33", cyc, to); end
    exp = sb32.pop_front();
    bus_read(REG_RESULT_LO, d32, d8);
    checks++;
    if (d32 !== exp[31:0] || d32 !== 32'd6) begin failures++; $display("[TB] FAIL post_reset_lo: got %h expected %h", d32, exp[31:0]); end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_unsigned_max();
    test_signed_irq();
    test_busy_ignore();
    test_width8_signed();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mymul_seq.md
Name: mymul_seq

Overview:
- Next-generation memory-mapped multiplier slave for the Avalon-MM system interconnect.
- Uses an iterative shift-add datapath with DATA_W-wide operands instead of a single-cycle 32x32 array.
- Adds signed mode, a busy/done status register, write-one-to-clear done, and an optional completion interrupt.
- Software flow: write A, B and CTRL.start, then either poll STATUS or wait for irq, then read RESULT_LO and RESULT_HI.

Parameters:
- DATA_W, 32, operand width; legal values 8, 16, 32; product width is 2*DATA_W.
- ADDR_W, 3, word-address width of the slave port.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  word address.
- read  in  1  read strobe.
- readdata  out  32  read data, combinational, zero-latency.
- write  in  1  write strobe.
- writedata  in  32  write data.
- irq  out  1  level interrupt; equals done & irq_en.

Behaviour:
- Register map (word offsets). All reads of registers narrower than 32 bits are zero-extended.
  - 0 A: rw; holds writedata[DATA_W-1:0].
  - 1 B: rw; holds writedata[DATA_W-1:0].
  - 2 RESULT_LO: ro; product[DATA_W-1:0].
  - 3 RESULT_HI: ro; product[2*DATA_W-1:DATA_W].
  - 4 CTRL: bit0 start (write-only pulse, reads 0), bit1 signed, bit2 irq_en.
  - 5 STATUS: bit0 busy, bit1 done. Writing 1 to bit1 clears done.
  - 6, 7: read 0; writes ignored.
- readdata = selected register when read=1, else 0. No waitrequest; every access completes in one cycle.
- Reset (reset_n low, asynchronous): A, B, RESULT_LO, RESULT_HI, signed, irq_en, busy, done all 0; FSM to IDLE; irq=0; readdata=0.
- FSM states: IDLE, RUN, FIN.
  - IDLE -> RUN on a CTRL write with writedata[0]=1.
    - signed and irq_en are latched from the same write.
    - done cleared, busy set.
    - Operand magnitudes loaded: |A|,|B| if signed, else raw. Result sign = A[msb]^B[msb] in signed mode.
    - Iteration counter cleared.
  - RUN: one shift-add step per cycle for DATA_W cycles (counter 0..DATA_W-1); then -> FIN.
  - FIN: one cycle. Conditionally two's-complement negate the 2*DATA_W accumulator, write RESULT_LO/HI, busy=0, done=1; -> IDLE.
- Latency: start accepted at edge E0; busy=1 from E0; results valid and done=1 after edge E0+DATA_W+1. STATUS.busy therefore reads 1 for exactly DATA_W+1 cycles.
- CTRL writes with start=0 update signed and irq_en in any state. The running operation keeps the mode latched at start.
- While busy:
  - writes to A and B are ignored;
  - start is ignored;
  - RESULT_LO/HI hold the previous values until FIN.
- Done-clear and FIN in the same cycle: FIN wins, done=1.
- Start and done-clear cannot coincide; they target different addresses.
- irq is registered-free: the combinational AND of the done and irq_en flops.
- Signed edge case: most-negative x most-negative gives a positive product that fits in 2*DATA_W bits.
- reset_n asserted mid-RUN aborts immediately; no partial result is written.

Decomposition:
- Shared package mymul_pkg:
  - register offsets (REG_A..REG_STATUS);
  - CTRL/STATUS bit indices;
  - FSM state enum (IDLE, RUN, FIN).
- Sub-module mymul_seq_core holds the datapath:
  - magnitude, shift-add accumulator, counter and final negate;
  - interface: start, signed, a, b -> busy, valid, product[2*DATA_W-1:0].
- The top level keeps the bus decode, register file, done/irq logic and readdata mux.

Test Plan:
- DATA_W=32, unsigned: A=7, B=6, start → busy=1 for 33 cycles; then done=1, RESULT_LO=42, RESULT_HI=0.
- Unsigned A=B=0xFFFFFFFF → LO=0x00000001, HI=0xFFFFFFFE.
- Signed A=0xFFFFFFFD (-3), B=5 → LO=0xFFFFFFF1, HI=0xFFFFFFFF. Then a STATUS write of 0x2 → done=0; irq was 1 with irq_en set and becomes 0.
- While busy on A=3, B=4:
  - write A=100 → ignored;
  - write start → ignored;
  - result LO=12, and exactly one done pulse rise.
- DATA_W=8, signed: A=0x80, B=0x80 → LO=0x00, HI=0x40. Reads of addresses 6 and 7 return 0.
- reset_n low at RUN cycle 10 → all registers 0, busy=0, done=0, irq=0. A fresh 2x3 afterwards yields LO=6.
